alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_sequencer.sv | 129 ++++++++++++
 tb/tb_alu_sequencer.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer slice: default widths, ALU opcode
// constants, the sequencer FSM encoding and the legal-opcode check.
package alu_pkg;

  localparam int ALU_SIZEDATA = 8;
  localparam int ALU_SIZEOP   = 6;

  localparam logic [5:0] OP_ADD = 6'h20;
  localparam logic [5:0] OP_SUB = 6'h22;
  localparam logic [5:0] OP_OR  = 6'h25;
  localparam logic [5:0] OP_XOR = 6'h26;
  localparam logic [5:0] OP_AND = 6'h24;
  localparam logic [5:0] OP_NOR = 6'h27;
  localparam logic [5:0] OP_SRA = 6'h03;
  localparam logic [5:0] OP_SRL = 6'h02;

  typedef enum logic [2:0] {
    LOAD_A  = 3'd0,
    LOAD_B  = 3'd1,
    LOAD_OP = 3'd2,
    EXEC    = 3'd3,
    SEND    = 3'd4
  } seq_state_t;

  // True when the zero-extended opcode is one the ALU implements.
  function automatic logic is_legal_op(input logic [31:0] op);
    case (op)
      32'(OP_ADD), 32'(OP_SUB), 32'(OP_OR),  32'(OP_XOR),
      32'(OP_AND), 32'(OP_NOR), 32'(OP_SRA), 32'(OP_SRL): is_legal_op = 1'b1;
      default:                                            is_legal_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_sequencer.sv
// ALU sequencer: collects operand A, operand B and an opcode from a byte
// stream, presents them to an external combinational ALU, captures the result
// and hands it downstream with a valid/ready handshake.
// Build option: define ALU_SEQ_OPCHECK_EN to reject illegal opcodes (result 0,
// ERROR set, EXEC skipped). Without it every opcode is executed and ERROR is 0.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int SIZEDATA = ALU_SIZEDATA,
  parameter int SIZEOP   = ALU_SIZEOP
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [SIZEDATA-1:0] RX_DATA,
  input  logic                RX_VALID,
  output logic                RX_READY,
  output logic [SIZEDATA-1:0] ALU_DATOA,
  output logic [SIZEDATA-1:0] ALU_DATOB,
  output logic [SIZEOP-1:0]   ALU_OPCODE,
  input  logic [SIZEDATA-1:0] ALU_RESULT,
  output logic [SIZEDATA-1:0] TX_DATA,
  output logic                TX_VALID,
  input  logic                TX_READY,
  output logic                BUSY,
  output logic                ERROR,
  output logic [15:0]         DONE_COUNT
);

  seq_state_t        state_q;
  seq_state_t        state_d;
  logic              accept;
  logic              tx_hs;
  logic              op_legal;
  logic [SIZEOP-1:0] rx_op;
  logic [15:0]       done_cnt;

  assign rx_op      = RX_DATA[SIZEOP-1:0];
  assign accept     = RX_VALID && RX_READY;
  assign tx_hs      = TX_VALID && TX_READY;
  assign DONE_COUNT = done_cnt;

`ifdef ALU_SEQ_OPCHECK_EN
  logic error_q;
  assign op_legal = is_legal_op(32'(rx_op));
  assign ERROR    = error_q;
`else
  assign op_legal = 1'b1;
  assign ERROR    = 1'b0;
`endif

  // Next-state decode plus the RX_READY/BUSY flags derived from the state.
  always_comb begin
    state_d  = state_q;
    RX_READY = 1'b0;
    BUSY     = 1'b1;
    case (state_q)
      LOAD_A: begin
        RX_READY = !RESET;
        BUSY     = 1'b0;
        if (RX_VALID && !RESET) state_d = LOAD_B;
      end
      LOAD_B: begin
        RX_READY = !RESET;
        if (RX_VALID && !RESET) state_d = LOAD_OP;
      end
      LOAD_OP: begin
        RX_READY = !RESET;
        if (RX_VALID && !RESET) state_d = op_legal ? EXEC : SEND;
      end
      EXEC:    state_d = SEND;
      SEND:    if (tx_hs) state_d = LOAD_A;
      default: state_d = LOAD_A;
    endcase
  end

  // State register; reset abandons whatever transaction was in flight.
  always_ff @(posedge CLK) begin
    if (RESET) state_q <= LOAD_A;
    else       state_q <= state_d;
  end

  // Operand/opcode capture, result capture and completion bookkeeping.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      ALU_DATOA  <= '0;
      ALU_DATOB  <= '0;
      ALU_OPCODE <= '0;
      TX_DATA    <= '0;
      TX_VALID   <= 1'b0;
      done_cnt   <= 16'd0;
`ifdef ALU_SEQ_OPCHECK_EN
      error_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        LOAD_A:  if (accept) ALU_DATOA <= RX_DATA;
        LOAD_B:  if (accept) ALU_DATOB <= RX_DATA;
        LOAD_OP: begin
          if (accept) begin
            ALU_OPCODE <= rx_op;
`ifdef ALU_SEQ_OPCHECK_EN
            // Illegal opcode: publish a zero result flagged as an error.
            if (!op_legal) begin
              TX_DATA  <= '0;
              TX_VALID <= 1'b1;
              error_q  <= 1'b1;
            end
`endif
          end
        end
        EXEC: begin
          TX_DATA  <= ALU_RESULT;
          TX_VALID <= 1'b1;
        end
        SEND: begin
          if (tx_hs) begin
            TX_VALID <= 1'b0;
            done_cnt <= done_cnt + 16'd1;
`ifdef ALU_SEQ_OPCHECK_EN
            error_q  <= 1'b0;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a scoreboard: every transaction pushes
// its expected result, a monitor pops and compares on each TX handshake.
module tb_alu_sequencer;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [7:0] RX_DATA;
  logic       RX_VALID;
  logic       RX_READY;
  logic [7:0] ALU_DATOA;
  logic [7:0] ALU_DATOB;
  logic [5:0] ALU_OPCODE;
  logic [7:0] ALU_RESULT;
  logic [7:0] TX_DATA;
  logic       TX_VALID;
  logic       TX_READY;
  logic       BUSY;
  logic       ERROR;
  logic [15:0] DONE_COUNT;

  typedef struct packed {
    logic [7:0] data;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 CLK = ~CLK;

  alu_sequencer #(.SIZEDATA(8), .SIZEOP(6)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .RX_DATA    (RX_DATA),
    .RX_VALID   (RX_VALID),
    .RX_READY   (RX_READY),
    .ALU_DATOA  (ALU_DATOA),
    .ALU_DATOB  (ALU_DATOB),
    .ALU_OPCODE (ALU_OPCODE),
    .ALU_RESULT (ALU_RESULT),
    .TX_DATA    (TX_DATA),
    .TX_VALID   (TX_VALID),
    .TX_READY   (TX_READY),
    .BUSY       (BUSY),
    .ERROR      (ERROR),
    .DONE_COUNT (DONE_COUNT)
  );

  // Reference ALU sitting beside the sequencer; unknown opcodes yield 0.
  always_comb begin
    case (ALU_OPCODE)
      6'h20:   ALU_RESULT = ALU_DATOA + ALU_DATOB;
      6'h22:   ALU_RESULT = ALU_DATOA - ALU_DATOB;
      6'h25:   ALU_RESULT = ALU_DATOA | ALU_DATOB;
      6'h26:   ALU_RESULT = ALU_DATOA ^ ALU_DATOB;
      6'h24:   ALU_RESULT = ALU_DATOA & ALU_DATOB;
      6'h27:   ALU_RESULT = ~(ALU_DATOA | ALU_DATOB);
      6'h03:   ALU_RESULT = 8'($signed(ALU_DATOA) >>> ALU_DATOB);
      6'h02:   ALU_RESULT = ALU_DATOA >> ALU_DATOB;
      default: ALU_RESULT = 8'h00;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: a handshake happens at the next rising edge whenever both
  // TX_VALID and TX_READY are high at the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (!RESET && TX_VALID && TX_READY) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL tx_unexpected: got data 0x%0h, want no output", TX_DATA);
        end else begin
          e = exp_q.pop_front();
          check("tx_data", 32'(TX_DATA), 32'(e.data));
          check("tx_error", 32'(ERROR), 32'(e.err));
        end
      end
    end
  end

  // Offer one byte and hold it until the sequencer takes it.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    RX_DATA  = b;
    RX_VALID = 1'b1;
    @(negedge CLK);
    while (!RX_READY && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (!RX_READY) begin
      n_cmp++;
      n_bad++;
      $display("FAIL rx_timeout: got RX_READY=0, want 1 for byte 0x%0h", b);
    end
    @(posedge CLK);
    #1;
    RX_VALID = 1'b0;
  endtask

  task automatic push_exp(input logic [7:0] d, input logic er);
    exp_t e;
    e.data = d;
    e.err  = er;
    exp_q.push_back(e);
  endtask

  task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                         input logic [7:0] d, input logic er);
    push_exp(d, er);
    send_byte(a);
    send_byte(b);
    send_byte(op);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge CLK);
    while ((BUSY || TX_VALID) && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (BUSY || TX_VALID) begin
      n_cmp++;
      n_bad++;
      $display("FAIL idle_timeout: got BUSY=%0b, want 0", BUSY);
    end
  endtask

  initial begin
    logic [15:0] cnt0;
    RESET    = 1'b1;
    RX_DATA  = 8'h00;
    RX_VALID = 1'b0;
    TX_READY = 1'b1;

    // Reset state
    @(negedge CLK);
    check("rst_rx_ready", 32'(RX_READY), 0);
    @(posedge CLK); #1;
    RESET = 1'b0;
    @(negedge CLK);
    check("rst_busy", 32'(BUSY), 0);
    check("rst_tx_valid", 32'(TX_VALID), 0);
    check("rst_done", 32'(DONE_COUNT), 0);
    check("rst_datoa", 32'(ALU_DATOA), 0);
    check("rst_opcode", 32'(ALU_OPCODE), 0);
    check("rst_error", 32'(ERROR), 0);
    check("rst_rx_ready_after", 32'(RX_READY), 1);
    @(posedge CLK); #1;

    // ADD 5+3 with latency check
    run_txn(8'h05, 8'h03, 8'h20, 8'h08, 1'b0);
    @(negedge CLK);
    check("exec_tx_valid", 32'(TX_VALID), 0);
    check("exec_busy", 32'(BUSY), 1);
    @(negedge CLK);
    check("lat2_tx_valid", 32'(TX_VALID), 1);
    wait_idle();
    check("add_done", 32'(DONE_COUNT), 1);
    check("hold_datoa", 32'(ALU_DATOA), 32'h05);
    check("hold_datob", 32'(ALU_DATOB), 32'h03);
    check("hold_opcode", 32'(ALU_OPCODE), 32'h20);
    @(posedge CLK); #1;

    // SUB and SRA
    run_txn(8'h03, 8'h05, 8'h22, 8'hFE, 1'b0);
    wait_idle();
    @(posedge CLK); #1;
    run_txn(8'h80, 8'h02, 8'h03, 8'hE0, 1'b0);
    wait_idle();
    @(posedge CLK); #1;

    // OR with downstream back-pressure, then RX byte offered at the handshake
    TX_READY = 1'b0;
    run_txn(8'h0F, 8'hF0, 8'h25, 8'hFF, 1'b0);
    push_exp(8'h08, 1'b0);
    RX_DATA  = 8'h07;
    RX_VALID = 1'b1;
    @(posedge CLK); #1;
    cnt0 = DONE_COUNT;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check("bp_tx_valid", 32'(TX_VALID), 1);
      check("bp_tx_data", 32'(TX_DATA), 32'hFF);
      check("bp_rx_ready", 32'(RX_READY), 0);
      check("bp_busy", 32'(BUSY), 1);
    end
    @(posedge CLK); #1;
    TX_READY = 1'b1;
    @(posedge CLK); #1;
    check("bp_one_handshake", 32'(DONE_COUNT), 32'(cnt0 + 16'd1));
    check("bp_rx_not_taken", 32'(ALU_DATOA), 32'h0F);
    @(posedge CLK); #1;
    check("bp_rx_taken_next", 32'(ALU_DATOA), 32'h07);
    RX_VALID = 1'b0;
    send_byte(8'h01);
    send_byte(8'h20);
    wait_idle();
    check("bp_done_after", 32'(DONE_COUNT), 32'(cnt0 + 16'd2));
    @(posedge CLK); #1;

    // Reset in the middle of a transaction
    send_byte(8'h11);
    send_byte(8'h22);
    RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    check("mid_rst_datoa", 32'(ALU_DATOA), 0);
    check("mid_rst_datob", 32'(ALU_DATOB), 0);
    check("mid_rst_busy", 32'(BUSY), 0);
    run_txn(8'h04, 8'h01, 8'h02, 8'h02, 1'b0);
    wait_idle();
    check("mid_rst_new_a", 32'(ALU_DATOA), 32'h04);
    check("mid_rst_done", 32'(DONE_COUNT), 1);
    @(posedge CLK); #1;

    // Illegal opcode 0x3F
`ifdef ALU_SEQ_OPCHECK_EN
    TX_READY = 1'b0;
    run_txn(8'h01, 8'h01, 8'h3F, 8'h00, 1'b1);
    @(negedge CLK);
    check("ill_skip_exec", 32'(TX_VALID), 1);
    check("ill_tx_data", 32'(TX_DATA), 0);
    check("ill_error", 32'(ERROR), 1);
    @(negedge CLK);
    check("ill_error_hold", 32'(ERROR), 1);
    @(posedge CLK); #1;
    TX_READY = 1'b1;
    wait_idle();
    check("ill_error_clr", 32'(ERROR), 0);
`else
    run_txn(8'h01, 8'h01, 8'h3F, 8'h00, 1'b0);
    @(negedge CLK);
    check("ill_exec_tx_valid", 32'(TX_VALID), 0);
    @(negedge CLK);
    check("ill_lat2_tx_valid", 32'(TX_VALID), 1);
    check("ill_error_zero", 32'(ERROR), 0);
    wait_idle();
`endif
    @(posedge CLK); #1;

    // DONE_COUNT wrap: preload as if 65535 transactions had completed
    @(negedge CLK);
    dut.done_cnt = 16'hFFFF;
    @(negedge CLK);
    check("wrap_preload", 32'(DONE_COUNT), 32'hFFFF);
    @(posedge CLK); #1;
    run_txn(8'h02, 8'h02, 8'h20, 8'h04, 1'b0);
    wait_idle();
    check("wrap_done", 32'(DONE_COUNT), 0);

    repeat (3) @(negedge CLK);
    check("sb_empty", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion, want finish");
    $fatal(1, "timeout");
  end

endmodule
